// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, buffers {pc, instr} pairs in a
// small FIFO and hands them to decode; redirects flush the queue.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic [31:0] pc_o,
    input  logic [31:0] instr_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    output logic        id_valid_o,
    input  logic        id_ready_i,
    output logic [31:0] id_instr_o,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_pc_plus4_o,
    output logic        misaligned_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PONE = AW'(1);
    localparam logic [AW:0] CONE = (AW+1)'(1);

    logic [31:0]   pc;
    logic [31:0]   st_pc    [DEPTH];
    logic [31:0]   st_instr [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;
    logic          pop;
    logic          push;

    always_comb begin
        pop  = 1'b0;
        push = 1'b0;
        pop  = id_valid_o & id_ready_i;
        // A pop on a full queue frees the slot we write this same edge.
        push = !redirect_valid_i & ((count < FULL) | pop);
    end

    assign pc_o          = pc;
    assign id_valid_o    = (count != '0);
    assign id_instr_o    = st_instr[rd_ptr];
    assign id_pc_o       = st_pc[rd_ptr];
    assign id_pc_plus4_o = id_pc_o + 32'd4;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc           <= RESET_PC;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            misaligned_o <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                st_pc[i]    <= '0;
                st_instr[i] <= '0;
            end
        end else begin
            misaligned_o <= redirect_valid_i &
                            (redirect_pc_i[1:0] != 2'b00);
            if (redirect_valid_i) begin
                pc     <= {redirect_pc_i[31:2], 2'b00};
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    st_pc[wr_ptr]    <= pc;
                    st_instr[wr_ptr] <= instr_i;
                    wr_ptr           <= wr_ptr + PONE;
                    pc               <= pc + 32'd4;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PONE;
                end
                if (push && !pop) begin
                    count <= count + CONE;
                end else if (pop && !push) begin
                    count <= count - CONE;
                end
            end
        end
    end

endmodule
